// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV core: opcode and funct encodings,
// FSM state codes, ALU operation enum and a small register-index helper.
package rv_pkg;

    // Major opcodes handled by the core
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 encodings for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 encodings for conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 encodings: base and alternate (SUB / SRA)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_EXEC  = 2'd1;
    localparam state_t ST_WB    = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    // ALU operations
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASSB
    } alu_op_e;

    // Map funct3 (plus the alternate-encoding bit) onto an ALU operation
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // True when a 5-bit register field names an implemented register
    function automatic logic reg_ok(input logic [4:0] idx, input int nreg);
        return int'(idx) < nreg;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational ALU for the multicycle RV core. Shifts use the low
// $clog2(XLEN) bits of operand b; arithmetic wraps modulo 2^XLEN.
module rv_alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    // Select the operation result
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_XOR:   result = a ^ b;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multicycle RV integer core: FETCH -> EXEC -> WB, with a terminal HALT state
// entered on any illegal instruction. Minimum 3 cycles per instruction.
// Optional feature: define RV_BRANCH_EN to add BEQ/BNE/BLT/BGE/BLTU/BGEU;
// without it the branch opcode is treated as illegal.
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_valid,
    input  logic [31:0]             imem_rdata,
    output logic                    retire,
    output logic                    illegal,
    input  logic [$clog2(NREG)-1:0] dbg_raddr,
    output logic [XLEN-1:0]         dbg_rdata
);

    localparam int              RW      = $clog2(NREG);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Architectural and pipeline-like state
    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     ir_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] next_pc_reg;
    logic            wen_reg;
    logic [4:0]      rd_reg;
    logic            illegal_reg;

    // Register file; x0 has no storage and always reads zero
    logic [XLEN-1:0] regs_reg [1:NREG-1];
    logic [NREG-1:0] reg_we;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_f;
    logic [2:0] f3;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [6:0] f7;
    logic [6:0] f7_sh;

    assign opcode = ir_reg[6:0];
    assign rd_f   = ir_reg[11:7];
    assign f3     = ir_reg[14:12];
    assign rs1_f  = ir_reg[19:15];
    assign rs2_f  = ir_reg[24:20];
    assign f7     = ir_reg[31:25];
    // On RV64 bit 25 belongs to the 6-bit shift amount, not to funct7
    assign f7_sh  = (XLEN == 64) ? {f7[6:1], 1'b0} : f7;

    // Sign-extended immediates
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
    assign imm_u = {{(XLEN-31){ir_reg[31]}}, ir_reg[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){ir_reg[31]}}, ir_reg[31], ir_reg[19:12],
                    ir_reg[20], ir_reg[30:21], 1'b0};
`ifdef RV_BRANCH_EN
    logic [XLEN-1:0] imm_b;
    assign imm_b = {{(XLEN-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                    ir_reg[30:25], ir_reg[11:8], 1'b0};
`endif

    // Register reads
    logic [RW-1:0]   rs1_idx;
    logic [RW-1:0]   rs2_idx;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rs1_idx   = rs1_f[RW-1:0];
    assign rs2_idx   = rs2_f[RW-1:0];
    assign rs1_val   = (rs1_idx == '0) ? '0 : regs_reg[rs1_idx];
    assign rs2_val   = (rs2_idx == '0) ? '0 : regs_reg[rs2_idx];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs_reg[dbg_raddr];

    // Decode outputs
    logic            dec_legal;
    logic            dec_wen;
    logic            dec_link;
    logic            need_rs1;
    logic            need_rs2;
    logic            need_rd;
    logic            dec_ok;
    logic [XLEN-1:0] dec_next_pc;
    logic [XLEN-1:0] pc_plus4;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    assign pc_plus4 = pc_reg + PC_STEP;

    rv_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (alu_op),
        .a      (rs1_val),
        .b      (alu_b),
        .result (alu_result)
    );

    // Decode the held instruction: legality, ALU setup and next PC
    always_comb begin
        dec_legal   = 1'b0;
        dec_wen     = 1'b0;
        dec_link    = 1'b0;
        need_rs1    = 1'b0;
        need_rs2    = 1'b0;
        need_rd     = 1'b0;
        dec_next_pc = pc_plus4;
        alu_op      = ALU_ADD;
        alu_b       = rs2_val;
        case (opcode)
            OPC_OP: begin
                need_rs1  = 1'b1;
                need_rs2  = 1'b1;
                need_rd   = 1'b1;
                dec_wen   = 1'b1;
                alu_b     = rs2_val;
                alu_op    = alu_from_f3(f3, f7 == F7_ALT);
                dec_legal = (f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                need_rs1 = 1'b1;
                need_rd  = 1'b1;
                dec_wen  = 1'b1;
                alu_b    = imm_i;
                alu_op   = alu_from_f3(f3, (f3 == F3_SR) && (f7_sh == F7_ALT));
                case (f3)
                    F3_SLL:  dec_legal = (f7_sh == F7_BASE);
                    F3_SR:   dec_legal = (f7_sh == F7_BASE) || (f7_sh == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                need_rd   = 1'b1;
                dec_wen   = 1'b1;
                alu_op    = ALU_PASSB;
                alu_b     = imm_u;
                dec_legal = 1'b1;
            end
            OPC_JAL: begin
                need_rd     = 1'b1;
                dec_wen     = 1'b1;
                dec_link    = 1'b1;
                dec_next_pc = pc_reg + imm_j;
                dec_legal   = 1'b1;
            end
`ifdef RV_BRANCH_EN
            OPC_BRANCH: begin
                need_rs1  = 1'b1;
                need_rs2  = 1'b1;
                dec_legal = 1'b1;
                case (f3)
                    F3_BEQ:  dec_next_pc = (rs1_val == rs2_val) ? pc_reg + imm_b : pc_plus4;
                    F3_BNE:  dec_next_pc = (rs1_val != rs2_val) ? pc_reg + imm_b : pc_plus4;
                    F3_BLT:  dec_next_pc = ($signed(rs1_val) < $signed(rs2_val)) ? pc_reg + imm_b : pc_plus4;
                    F3_BGE:  dec_next_pc = ($signed(rs1_val) >= $signed(rs2_val)) ? pc_reg + imm_b : pc_plus4;
                    F3_BLTU: dec_next_pc = (rs1_val < rs2_val) ? pc_reg + imm_b : pc_plus4;
                    F3_BGEU: dec_next_pc = (rs1_val >= rs2_val) ? pc_reg + imm_b : pc_plus4;
                    default: dec_legal = 1'b0;
                endcase
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // An instruction is executable only if every register it names exists
    assign dec_ok = dec_legal &&
                    (!need_rs1 || reg_ok(rs1_f, NREG)) &&
                    (!need_rs2 || reg_ok(rs2_f, NREG)) &&
                    (!need_rd  || reg_ok(rd_f,  NREG));

    // Next-state logic for the control FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: if (imem_valid) state_next = ST_EXEC;
            ST_EXEC:  state_next = dec_ok ? ST_WB : ST_HALT;
            ST_WB:    state_next = ST_FETCH;
            default:  state_next = ST_HALT;
        endcase
    end

    // Control state, PC, IR and the EXEC-to-WB holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            result_reg  <= '0;
            next_pc_reg <= RESET_PC;
            wen_reg     <= 1'b0;
            rd_reg      <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_FETCH: begin
                    if (imem_valid) ir_reg <= imem_rdata;
                end
                ST_EXEC: begin
                    if (dec_ok) begin
                        result_reg  <= dec_link ? pc_plus4 : alu_result;
                        next_pc_reg <= dec_next_pc;
                        wen_reg     <= dec_wen;
                        rd_reg      <= rd_f;
                    end else begin
                        illegal_reg <= 1'b1;
                    end
                end
                ST_WB: begin
                    pc_reg <= next_pc_reg;
                end
                default: ;
            endcase
        end
    end

    // Per-register write enables; only a WB of a writing op touches a register
    for (genvar gi = 0; gi < NREG; gi++) begin : g_we
        if (gi == 0) begin : g_x0
            assign reg_we[gi] = 1'b0;
        end else begin : g_xn
            assign reg_we[gi] = (state_reg == ST_WB) && wen_reg && (rd_reg == 5'(gi));
        end
    end

    // Register file storage, cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (reg_we[i]) regs_reg[i] <= result_reg;
            end
        end
    end

    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign retire    = (state_reg == ST_WB);
    assign illegal   = illegal_reg;

endmodule
